alu_seq: RTL and testbench

Parametrised, registered successor to the core's single-cycle ALU. Widens the operation set to eight ops, including shifts and an iterative multiply, and adds a Start/Busy/Done handshake. Results and NZCV flags are registered. It sits in the execute stage. The control unit stalls on Busy and consumes ALUResult/ALUFlag on Done.

---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered eight-operation ALU with an iterative shift-and-add multiplier.
// Single-cycle ops complete at the edge that accepts Start. MUL keeps Busy high for
// WIDTH cycles and then completes. Results and {N,Z,C,V} flags change only when an
// operation completes, or on reset.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlag,
    output logic             Busy,
    output logic             Done
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } stateT;

    stateT state;
    stateT stateNext;

    logic [SHW-1:0]   shiftAmount;
    logic [WIDTH:0]   addWide;
    logic [WIDTH:0]   subWide;
    logic [WIDTH:0]   lslWide;
    logic [WIDTH:0]   lsrWide;
    logic [WIDTH-1:0] opResult;
    logic             opCarry;
    logic             opOverflow;
    logic [3:0]       opFlags;

    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] accumulator;
    logic [SHW-1:0]   iterCount;
    logic [WIDTH-1:0] mulAddend;
    logic [WIDTH-1:0] accNext;
    logic             mulLast;
    logic [3:0]       mulFlags;

    logic             acceptOp;
    logic             acceptMul;
    logic             mulFinish;

    assign shiftAmount = SrcB[SHW-1:0];

    // Single-cycle datapath: one extra bit on each intermediate captures the carry or
    // the last bit shifted out, so no variable bit-select of SrcA is needed.
    always_comb begin
        addWide    = {1'b0, SrcA} + {1'b0, SrcB};
        subWide    = {1'b0, SrcA} - {1'b0, SrcB};
        lslWide    = {1'b0, SrcA} << shiftAmount;
        lsrWide    = {SrcA, 1'b0} >> shiftAmount;
        opResult   = '0;
        opCarry    = 1'b0;
        opOverflow = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                opResult   = addWide[WIDTH-1:0];
                opCarry    = addWide[WIDTH];
                opOverflow = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                             (addWide[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                opResult   = subWide[WIDTH-1:0];
                opCarry    = ~subWide[WIDTH];
                opOverflow = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                             (subWide[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND: opResult = SrcA & SrcB;
            OP_OR:  opResult = SrcA | SrcB;
            OP_XOR: opResult = SrcA ^ SrcB;
            OP_LSL: begin
                opResult = lslWide[WIDTH-1:0];
                opCarry  = lslWide[WIDTH];
            end
            OP_LSR: begin
                opResult = lsrWide[WIDTH:1];
                opCarry  = lsrWide[0];
            end
            default: begin
                opResult   = '0;
                opCarry    = 1'b0;
                opOverflow = 1'b0;
            end
        endcase
        opFlags = {opResult[WIDTH-1], (opResult == '0), opCarry, opOverflow};
    end

    // Multiplier step: the value the accumulator takes this cycle, which on the final
    // iteration is also the product written to ALUResult.
    always_comb begin
        mulAddend = multiplier[0] ? multiplicand : '0;
        accNext   = accumulator + mulAddend;
        mulLast   = (iterCount == SHW'(WIDTH - 1));
        mulFlags  = {accNext[WIDTH-1], (accNext == '0), 1'b0, 1'b0};
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode: Start is only honoured in IDLE, so a Start during MUL is dropped.
    always_comb begin
        stateNext = state;
        acceptOp  = 1'b0;
        acceptMul = 1'b0;
        mulFinish = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (ALUControl == OP_MUL) begin
                        acceptMul = 1'b1;
                        stateNext = MUL;
                    end else begin
                        acceptOp  = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mulLast) begin
                    mulFinish = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign Busy = (state == MUL);

    // Shift-and-add multiplier registers: load on accept, then one partial product per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            multiplicand <= '0;
            multiplier   <= '0;
            accumulator  <= '0;
            iterCount    <= '0;
        end else if (acceptMul) begin
            multiplicand <= SrcA;
            multiplier   <= SrcB;
            accumulator  <= '0;
            iterCount    <= '0;
        end else if (state == MUL) begin
            accumulator  <= accNext;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            iterCount    <= iterCount + SHW'(1);
        end
    end

    // Architectural outputs: written only on a completion, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ALUResult <= '0;
            ALUFlag   <= 4'b0000;
        end else if (acceptOp) begin
            ALUResult <= opResult;
            ALUFlag   <= opFlags;
        end else if (mulFinish) begin
            ALUResult <= accNext;
            ALUFlag   <= mulFlags;
        end
    end

    // Completion pulse: high for the single cycle after a result is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            Done <= 1'b0;
        end else begin
            Done <= acceptOp | mulFinish;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq at WIDTH=32 and WIDTH=8. Expected results
// are queued when an operation is issued and compared when Done is seen.
module tb_alu_seq;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] ORR = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] LSL = 3'b101;
    localparam logic [2:0] LSR = 3'b110;
    localparam logic [2:0] MUL = 3'b111;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        string       tag;
    } expT;

    logic        clk;
    logic        reset;

    logic        start32;
    logic [2:0]  ctl32;
    logic [31:0] srcA32;
    logic [31:0] srcB32;
    logic [31:0] result32;
    logic [3:0]  flag32;
    logic        busy32;
    logic        done32;

    logic        start8;
    logic [2:0]  ctl8;
    logic [7:0]  srcA8;
    logic [7:0]  srcB8;
    logic [7:0]  result8;
    logic [3:0]  flag8;
    logic        busy8;
    logic        done8;

    expT         expQ[$];
    int          total;
    int          bad;
    int          doneSeen;
    logic [31:0] lastRes;
    logic [3:0]  lastFlg;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .reset     (reset),
        .Start     (start32),
        .SrcA      (srcA32),
        .SrcB      (srcB32),
        .ALUControl(ctl32),
        .ALUResult (result32),
        .ALUFlag   (flag32),
        .Busy      (busy32),
        .Done      (done32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .Start     (start8),
        .SrcA      (srcA8),
        .SrcB      (srcB8),
        .ALUControl(ctl8),
        .ALUResult (result8),
        .ALUFlag   (flag8),
        .Busy      (busy8),
        .Done      (done8)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start32 = 1'b1;
        ctl32   = op;
        srcA32  = a;
        srcB32  = b;
    endtask

    task automatic applyStimulus8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1;
        ctl8   = op;
        srcA8  = a;
        srcB8  = b;
    endtask

    task automatic pushExpected(input logic [31:0] res, input logic [3:0] flg, input string tag);
        expT e;
        e.res = res;
        e.flg = flg;
        e.tag = tag;
        expQ.push_back(e);
    endtask

    // One clock; at the falling edge score any completion and check Busy/Done exclusion.
    task automatic tick();
        expT e;
        @(negedge clk);
        if (done32 === 1'b1) begin
            doneSeen++;
            checkOutput("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput({e.tag, "_res"}, result32, e.res);
                checkOutput({e.tag, "_flag"}, 32'(flag32), 32'(e.flg));
                lastRes = e.res;
                lastFlg = e.flg;
            end
        end
        checkOutput("busy_done_excl32", 32'(busy32 & done32), 32'd0);
        checkOutput("busy_done_excl8", 32'(busy8 & done8), 32'd0);
    endtask

    task automatic singleOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res, input logic [3:0] flg, input string tag);
        applyStimulus(op, a, b);
        pushExpected(res, flg, tag);
        tick();
        checkOutput({tag, "_done"}, 32'(done32), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy32), 32'd0);
        start32 = 1'b0;
        tick();
        checkOutput({tag, "_done_low"}, 32'(done32), 32'd0);
    endtask

    initial begin
        int busyCycles;
        int doneBefore;

        total    = 0;
        bad      = 0;
        doneSeen = 0;
        lastRes  = '0;
        lastFlg  = '0;
        reset    = 1'b1;
        start32  = 1'b0;
        ctl32    = ADD;
        srcA32   = '0;
        srcB32   = '0;
        start8   = 1'b0;
        ctl8     = ADD;
        srcA8    = '0;
        srcB8    = '0;

        // Reset values
        repeat (3) tick();
        checkOutput("rst_res", result32, 32'h0);
        checkOutput("rst_flag", 32'(flag32), 32'h0);
        checkOutput("rst_busy", 32'(busy32), 32'h0);
        checkOutput("rst_done", 32'(done32), 32'h0);
        reset = 1'b0;
        tick();

        // Single-cycle operations
        singleOp(ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, "add_ovf");
        singleOp(ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, "add_carry");
        singleOp(SUB, 32'd5,        32'd5,        32'h00000000, 4'b0110, "sub_eq");
        singleOp(SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 4'b1000, "sub_borrow");
        singleOp(SUB, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0011, "sub_ovf");
        singleOp(AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, "and");
        singleOp(ORR, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100, "or_zero");
        singleOp(XOR, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 4'b1000, "xor");
        singleOp(LSL, 32'h80000001, 32'd1,        32'h00000002, 4'b0010, "lsl1");
        singleOp(LSL, 32'h00000001, 32'h0000003F, 32'h80000000, 4'b1000, "lsl_mask31");
        singleOp(LSR, 32'h00000003, 32'd1,        32'h00000001, 4'b0010, "lsr1");
        singleOp(LSR, 32'h00000003, 32'd0,        32'h00000003, 4'b0000, "lsr0");

        // 32-bit multiply with an ADD attempted mid-flight
        applyStimulus(MUL, 32'h0000FFFF, 32'h00010001);
        pushExpected(32'hFFFFFFFF, 4'b1000, "mul32");
        tick();
        start32 = 1'b0;
        busyCycles = 0;
        while (busy32 === 1'b1 && busyCycles < 40) begin
            busyCycles++;
            if (busyCycles == 10) applyStimulus(ADD, 32'd1, 32'd1);
            if (busyCycles == 11) start32 = 1'b0;
            if (busyCycles == 20) begin
                checkOutput("mul32_hold_res", result32, lastRes);
                checkOutput("mul32_hold_flag", 32'(flag32), 32'(lastFlg));
            end
            tick();
        end
        checkOutput("mul32_busy_cycles", 32'(busyCycles), 32'd32);
        checkOutput("mul32_done", 32'(done32), 32'd1);
        doneBefore = doneSeen;
        repeat (3) tick();
        checkOutput("mul32_no_extra_done", 32'(doneSeen - doneBefore), 32'd0);
        checkOutput("mul32_res_kept", result32, 32'hFFFFFFFF);

        // 8-bit multiply
        applyStimulus8(MUL, 8'h10, 8'h10);
        tick();
        start8 = 1'b0;
        busyCycles = 0;
        while (busy8 === 1'b1 && busyCycles < 20) begin
            busyCycles++;
            tick();
        end
        checkOutput("mul8_busy_cycles", 32'(busyCycles), 32'd8);
        checkOutput("mul8_done", 32'(done8), 32'd1);
        checkOutput("mul8_res", 32'(result8), 32'h00);
        checkOutput("mul8_flag", 32'(flag8), 32'(4'b0100));
        tick();
        checkOutput("mul8_done_low", 32'(done8), 32'd0);

        applyStimulus8(MUL, 8'h0D, 8'h0B);
        tick();
        start8 = 1'b0;
        busyCycles = 0;
        while (busy8 === 1'b1 && busyCycles < 20) begin
            busyCycles++;
            tick();
        end
        checkOutput("mul8b_busy_cycles", 32'(busyCycles), 32'd8);
        checkOutput("mul8b_res", 32'(result8), 32'h8F);
        checkOutput("mul8b_flag", 32'(flag8), 32'(4'b1000));

        applyStimulus8(LSL, 8'h81, 8'h09);
        tick();
        start8 = 1'b0;
        checkOutput("lsl8_done", 32'(done8), 32'd1);
        checkOutput("lsl8_res", 32'(result8), 32'h02);
        checkOutput("lsl8_flag", 32'(flag8), 32'(4'b0010));
        tick();

        // Reset in cycle 10 of a 32-bit multiply discards it
        applyStimulus(MUL, 32'h12345678, 32'h00000003);
        tick();
        start32 = 1'b0;
        repeat (9) tick();
        checkOutput("rstmul_busy_before", 32'(busy32), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lastRes = '0;
        lastFlg = '0;
        checkOutput("rstmul_busy", 32'(busy32), 32'd0);
        checkOutput("rstmul_done", 32'(done32), 32'd0);
        checkOutput("rstmul_res", result32, 32'h0);
        checkOutput("rstmul_flag", 32'(flag32), 32'h0);
        doneBefore = doneSeen;
        repeat (40) tick();
        checkOutput("rstmul_no_done", 32'(doneSeen - doneBefore), 32'd0);
        checkOutput("rstmul_busy_after", 32'(busy32), 32'd0);

        // Start held high for three back-to-back ADDs
        applyStimulus(ADD, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            pushExpected(32'h00000003, 4'b0000, "b2b_add");
            tick();
            checkOutput("b2b_done", 32'(done32), 32'd1);
        end
        start32 = 1'b0;
        tick();
        checkOutput("b2b_done_low", 32'(done32), 32'd0);
        checkOutput("b2b_res", result32, 32'h00000003);
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
